// File: rtl/pe_pkg.sv
// Shared widths, row type and error-bit positions for the PE result collector.
package pe_pkg;

  localparam int PE_INT_BITS  = 7;
  localparam int PE_FRAC_BITS = 9;
  localparam int W            = PE_INT_BITS + PE_FRAC_BITS;
  localparam int NUM_ACC_DEF  = 8;

  typedef logic [NUM_ACC_DEF-1:0][W-1:0] row_t;

  localparam int ERR_BAD_IDX = 0;
  localparam int ERR_DUP     = 1;
  localparam int ERR_OVF     = 2;

endpackage

// File: rtl/pe_row_fifo.sv
// Small synchronous FIFO of completed rows; the head entry is presented from
// the storage registers and reads as zero while the queue is empty.
module pe_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_result_collector.sv
// Assembles per-accumulator rounded results into rows, queues completed rows
// and drains them over valid/ready, with back-pressure and sticky error flags.
module pe_result_collector
  import pe_pkg::*;
#(
  parameter int para_int_bits  = PE_INT_BITS,
  parameter int para_frac_bits = PE_FRAC_BITS,
  parameter int NUM_ACC        = NUM_ACC_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int ROW_ID_W       = 8,
  localparam int DW = para_int_bits + para_frac_bits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DW-1:0]         pe_data,
  input  logic                  pe_valid,
  input  logic [3:0]            pe_number,
  output logic [NUM_ACC*DW-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROW_ID_W-1:0]   out_row_id,
  output logic                  stall,
  output logic [2:0]            err_flags
);

  localparam int RW = NUM_ACC * DW;
  localparam int FW = ROW_ID_W + RW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_ACC-1:0][DW-1:0] bank;
  logic [NUM_ACC-1:0][DW-1:0] merged;
  logic [NUM_ACC-1:0]         mask;
  logic [NUM_ACC-1:0]         merged_mask;
  logic [15:0]                mask_ext;
  logic                       held;
  logic [ROW_ID_W-1:0]        row_id;
  logic                       stall_q;
  logic [2:0]                 err;
  logic                       in_range;
  logic                       accept;
  logic                       dup;
  logic                       complete;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [FW-1:0]              fifo_head;

  // Handshake: a row transfers on a cycle where out_valid and out_ready are both
  // high; out_data/out_row_id hold steady while out_valid is high and not taken.
  assign fifo_pop  = !fifo_empty && out_ready;
  assign in_range  = 32'(pe_number) < NUM_ACC;
  assign accept    = pe_valid && !held && in_range;
  assign mask_ext  = 16'(mask);
  assign dup       = accept && mask_ext[pe_number];

  always_comb begin
    merged      = bank;
    merged_mask = mask;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (accept && (32'(pe_number) == i)) begin
        merged[i]      = pe_data;
        merged_mask[i] = 1'b1;
      end
    end
  end

  // A held row keeps its mask full, so it re-requests the push every cycle.
  assign complete  = &merged_mask;
  assign fifo_push = complete && (!fifo_full || fifo_pop) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank    <= '0;
      mask    <= '0;
      held    <= 1'b0;
      row_id  <= '0;
      stall_q <= 1'b0;
      err     <= '0;
    end else if (clear) begin
      bank    <= '0;
      mask    <= '0;
      held    <= 1'b0;
      row_id  <= '0;
      stall_q <= 1'b0;
      err     <= '0;
    end else begin
      stall_q <= (fifo_count >= CW'(FIFO_DEPTH - 1)) || held;
      if (pe_valid && held)              err[ERR_OVF]     <= 1'b1;
      if (pe_valid && !held && !in_range) err[ERR_BAD_IDX] <= 1'b1;
      if (dup)                           err[ERR_DUP]     <= 1'b1;
      bank <= merged;
      if (fifo_push) begin
        mask   <= '0;
        held   <= 1'b0;
        row_id <= row_id + ROW_ID_W'(1);
      end else begin
        mask <= merged_mask;
        held <= complete;
      end
    end
  end

  pe_row_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ({row_id, merged}),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head[RW-1:0];
  assign out_row_id = fifo_head[FW-1:RW];
  assign stall      = stall_q;
  assign err_flags  = err;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: row assembly, queueing, hold/stall,
// error flags, reset and clear.
module tb_pe_result_collector;
  import pe_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [15:0]  pe_data;
  logic         pe_valid;
  logic [3:0]   pe_number;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_row_id;
  logic         stall;
  logic [2:0]   err_flags;

  int tests = 0;
  int fails = 0;
  int ord[8] = '{7, 3, 0, 1, 2, 4, 5, 6};

  pe_result_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .pe_data    (pe_data),
    .pe_valid   (pe_valid),
    .pe_number  (pe_number),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row_id (out_row_id),
    .stall      (stall),
    .err_flags  (err_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input int n, input logic [15:0] d);
    pe_valid  = 1'b1;
    pe_number = 4'(n);
    pe_data   = d;
    tick();
    pe_valid  = 1'b0;
  endtask

  task automatic write_row(input logic [15:0] base, input bit ooo);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = ooo ? ord[k] : k;
      write_slot(n, base + 16'(n));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [127:0] row_of(input logic [15:0] base);
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = base + 16'(i);
    return r;
  endfunction

  initial begin
    logic [127:0] exp_row;
    rst_n = 1'b0; clear = 1'b0; pe_valid = 1'b0; pe_number = '0;
    pe_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_row_id", out_row_id, 8'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err_flags, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();

    // In-order row, downstream ready.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) write_slot(i, 16'h0100 + 16'(i));
    check("t1_no_valid_early", out_valid, 1'b0);
    write_slot(7, 16'h0107);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, row_of(16'h0100));
    check("t1_row_id", out_row_id, 8'd0);
    check("t1_mask_clear", dut.mask, 8'h00);
    tick();
    check("t1_popped", out_valid, 1'b0);
    out_ready = 1'b0;
    do_clear();

    // Out-of-order rows queue up; stall trails the count by one cycle.
    write_row(16'h0200, 1'b1);
    write_row(16'h0300, 1'b1);
    check("t2_head_id", out_row_id, 8'd0);
    check("t2_head_data", out_data, row_of(16'h0200));
    check("t2_count", dut.u_fifo.count, 3'd2);
    check("t2_stall_lo", stall, 1'b0);
    write_row(16'h0400, 1'b0);
    check("t2_count3", dut.u_fifo.count, 3'd3);
    check("t2_stall_not_yet", stall, 1'b0);
    tick();
    check("t2_stall_hi", stall, 1'b1);

    // Fill the queue, then hold a fifth row and overflow.
    write_row(16'h0500, 1'b0);
    write_row(16'h0600, 1'b0);
    check("t3_full", dut.u_fifo.count, 3'd4);
    check("t3_held", dut.held, 1'b1);
    write_slot(0, 16'hdead);
    check("t3_err_ovf", err_flags, 3'b100);
    check("t3_stall", stall, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_held_clr", dut.held, 1'b0);
    check("t3_head_id1", out_row_id, 8'd1);
    check("t3_count", dut.u_fifo.count, 3'd4);
    tick();
    check("t3_data_stable", out_data, row_of(16'h0300));
    out_ready = 1'b1;
    tick();
    check("t3_head_id2", out_row_id, 8'd2);
    tick();
    tick();
    check("t3_head_id4", out_row_id, 8'd4);
    check("t3_held_data", out_data, row_of(16'h0600));
    tick();
    check("t3_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    do_clear();
    check("clr_err", err_flags, 3'b000);

    // Bad index and duplicate slot.
    write_slot(9, 16'h0999);
    check("t4_err_bad", err_flags, 3'b001);
    write_slot(0, 16'h0700);
    write_slot(1, 16'h0701);
    write_slot(2, 16'h0011);
    write_slot(2, 16'h0022);
    for (int i = 3; i < 8; i++) write_slot(i, 16'h0700 + 16'(i));
    exp_row = row_of(16'h0700);
    exp_row[47:32] = 16'h0022;
    check("t4_err_dup", err_flags, 3'b011);
    check("t4_lane2", out_data[47:32], 16'h0022);
    check("t4_row", out_data, exp_row);
    check("t4_row_id", out_row_id, 8'd0);

    // Push and pop together into a full queue.
    write_row(16'h0a00, 1'b0);
    write_row(16'h0b00, 1'b0);
    write_row(16'h0c00, 1'b0);
    check("t5_full", dut.u_fifo.count, 3'd4);
    for (int i = 0; i < 7; i++) write_slot(i, 16'h0d00 + 16'(i));
    out_ready = 1'b1;
    write_slot(7, 16'h0d07);
    out_ready = 1'b0;
    check("t5_count", dut.u_fifo.count, 3'd4);
    check("t5_no_held", dut.held, 1'b0);
    check("t5_err", err_flags, 3'b011);
    check("t5_head_id", out_row_id, 8'd1);

    // Asynchronous reset mid-row with two rows queued.
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("t6_count2", dut.u_fifo.count, 3'd2);
    for (int i = 0; i < 3; i++) write_slot(i, 16'h0e00 + 16'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, '0);
    check("t6_rst_id", out_row_id, 8'd0);
    check("t6_rst_stall", stall, 1'b0);
    check("t6_rst_err", err_flags, 3'b000);
    tick();
    rst_n = 1'b1;
    write_row(16'h0900, 1'b0);
    check("t6_after_rst_id", out_row_id, 8'd0);
    check("t6_after_rst_data", out_data, row_of(16'h0900));

    // Same check through clear.
    write_row(16'h0f00, 1'b1);
    for (int i = 0; i < 3; i++) write_slot(i, 16'h0e00 + 16'(i));
    write_slot(12, 16'h0123);
    check("t7_err_pre", err_flags, 3'b001);
    do_clear();
    check("t7_clr_valid", out_valid, 1'b0);
    check("t7_clr_data", out_data, '0);
    check("t7_clr_id", out_row_id, 8'd0);
    check("t7_clr_err", err_flags, 3'b000);
    check("t7_clr_mask", dut.mask, 8'h00);
    write_row(16'h0800, 1'b0);
    check("t7_after_clr_id", out_row_id, 8'd0);
    check("t7_after_clr_data", out_data, row_of(16'h0800));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
Downstream stage of the PE unit. Captures each rounded accumulator result (data, valid, accumulator index) and assembles one result per accumulator slot into a full row. Completed rows are queued in a small FIFO and drained through a valid/ready interface to the writeback path. Issues a stall request back to the PE controller before the queue overflows.

Parameters:
para_int_bits, 7, integer bits of a rounded result
para_frac_bits, 9, fractional bits of a rounded result
NUM_ACC, 8, accumulator slots per row (1..16)
FIFO_DEPTH, 4, completed-row queue depth (>=2, power of 2)
ROW_ID_W, 8, row sequence counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear: empties the row bank and FIFO, zeroes the row id and error flags
pe_data  in  W=para_int_bits+para_frac_bits  rounded result from the PE
pe_valid  in  1  pe_data and pe_number valid this cycle
pe_number  in  4  accumulator index of pe_data
out_data  out  NUM_ACC*W  assembled row; lane i at [i*W +: W]
out_valid  out  1  out_data and out_row_id valid
out_ready  in  1  downstream accepts the row
out_row_id  out  ROW_ID_W  sequence number of the row at the FIFO head
stall  out  1  request to the PE controller to halt rounder_en / assert keep
err_flags  out  3  sticky: [0] bad index, [1] duplicate slot, [2] overflow drop

Behaviour:
- Reset (async, rst_n=0): row bank data=0, fill mask=0, held=0, FIFO empty, row id counter=0. Outputs: out_valid=0, out_data=0, out_row_id=0, stall=0, err_flags=0.
- clear has priority over all other synchronous activity. Same reset values; takes effect at the next edge.
- Capture: on pe_valid with pe_number<NUM_ACC and held=0, write pe_data into lane pe_number and set mask bit.
  - pe_number>=NUM_ACC: drop the write, set err_flags[0].
  - Target mask bit already set: overwrite the lane, set err_flags[1].
- Row completion: when the mask including the current write is all ones, push the merged row (current write included) into the FIFO at the same edge with row id = counter. Then counter+1 (wraps at 2^ROW_ID_W), mask clears.
- Push is permitted when FIFO count<FIFO_DEPTH, or when a pop occurs in the same cycle (simultaneous push/pop at full is legal).
- If a completed row cannot be pushed, the bank holds it (held=1, mask stays full). It is pushed at the first edge where a push is permitted, then held clears.
- Any pe_valid while held=1 is dropped and sets err_flags[2]; the bad-index and duplicate checks are not applied.
- Output: FIFO head drives out_data/out_row_id directly from registers. out_valid=(count>0). Pop on out_valid&&out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Latency: the write completing a row at edge N with the FIFO empty gives out_valid=1 in cycle N+1.
- stall = registered (count>=FIFO_DEPTH-1) || held. It updates one cycle after the count changes. The controller must honor it within 3 cycles (rounder pipeline depth); FIFO_DEPTH>=2 guarantees one spare slot covers that window.
- err_flags are sticky until reset or clear and never block capture.
- A partial row persists indefinitely; no timeout.

Decomposition:
- Shared package pe_pkg holds:
  - W derived localparam
  - NUM_ACC default
  - row_t typedef (packed array [NUM_ACC][W])
  - error bit index constants ERR_BAD_IDX=0, ERR_DUP=1, ERR_OVF=2
- One sub-module, pe_row_fifo: synchronous FIFO, parameterized width and depth, async active-low reset, sync clear. Interface: push/pop/full/empty/count, registered head output.

Test Plan:
- Write slots 0..7 in order, data 16'h0100+i, out_ready=1 -> out_valid one cycle after the slot-7 write; out_data lane i=16'h0100+i, out_row_id=0; mask cleared.
- Out-of-order slots 7,3,0,1,2,4,5,6 twice, out_ready=0 -> two FIFO entries, ids 0 and 1. Stall rises one cycle after count reaches 3.
- Fill the FIFO (4 rows), complete a 5th row with out_ready=0, then send pe_valid -> held=1, the extra write is dropped, err_flags=3'b100. Pulse out_ready once -> the held row is pushed next edge with id 4.
- pe_number=9, then slot 2 written twice (16'h0011, then 16'h0022) -> err_flags=3'b011; lane 2 of the completed row = 16'h0022.
- FIFO full; row completes in the same cycle out_ready=1 -> simultaneous push/pop, count stays 4, no held, no error.
- Assert rst_n low mid-row with 3 slots filled and 2 rows queued -> all outputs 0 immediately. After release, a full 8-slot row gets out_row_id=0. Repeat the check using clear.
